// File: rtl/shutdown_monitor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : shutdown_monitor
// Purpose  : Safety supervisor for the GPIO disable stage. It synchronizes and
//            debounces the kill switch and the undervolt comparator, watches
//            the CPU heartbeat, keeps sticky fault latches and sequences
//            SHUTDOWN -> HOLDOFF -> RUN.
// Ports    : clk        - single clock
//            reset_n    - synchronous active-low reset
//            kill_sw_n  - raw kill switch, 0 = kill
//            undervolt  - raw battery-low comparator, 1 = fault
//            heartbeat  - CPU heartbeat, each rising edge is one beat
//            wdt_enable - watchdog enable
//            clear      - fault clear / re-arm request
//            shutdown   - {not_running, wdt_fault, uv_fault, kill_fault}
//            state      - FSM state (00 SHUTDOWN, 01 HOLDOFF, 10 RUN)
// Revision : 1.0 - initial release
// ============================================================================
module shutdown_monitor #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned WDT_CYCLES      = 1000,
  parameter int unsigned HOLDOFF_CYCLES  = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       kill_sw_n,
  input  logic       undervolt,
  input  logic       heartbeat,
  input  logic       wdt_enable,
  input  logic       clear,
  output logic [3:0] shutdown,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_SHUTDOWN = 2'b00,
    ST_HOLDOFF  = 2'b01,
    ST_RUN      = 2'b10
  } state_t;

  localparam logic [15:0] c_db_target = 16'(DEBOUNCE_CYCLES);
  localparam logic [23:0] c_wdt_limit = 24'(WDT_CYCLES);
  localparam logic [15:0] c_ho_last   = 16'(HOLDOFF_CYCLES - 1);

  // Synchronizers (meta -> sync), plus a delayed heartbeat for edge detect
  logic kill_meta_q, kill_sync_q;
  logic uv_meta_q, uv_sync_q;
  logic hb_meta_q, hb_sync_q, hb_prev_q;

  // Debounce state
  logic        kill_deb_q, kill_deb_d;
  logic [15:0] kill_cnt_q, kill_cnt_d;
  logic        uv_deb_q, uv_deb_d;
  logic [15:0] uv_cnt_q, uv_cnt_d;

  // Watchdog, holdoff, latches, FSM, outputs
  logic [23:0] wdt_cnt_q, wdt_cnt_d;
  logic [15:0] ho_cnt_q, ho_cnt_d;
  logic [2:0]  latch_q, latch_d;   // {wdt, uv, kill}
  state_t      state_q, state_d;
  logic [3:0]  shutdown_q, shutdown_d;

  logic        kill_active, uv_active, hb_edge, wdt_cond;
  logic [2:0]  set_vec;
  logic [15:0] kill_cnt_inc, uv_cnt_inc;

  assign kill_active  = ~kill_deb_q;
  assign uv_active    = uv_deb_q;
  assign hb_edge      = hb_sync_q & ~hb_prev_q;
  assign kill_cnt_inc = kill_cnt_q + 16'd1;
  assign uv_cnt_inc   = uv_cnt_q + 16'd1;

  // A heartbeat edge on the limit cycle suppresses the fault.
  assign wdt_cond = (state_q == ST_RUN) && wdt_enable && !hb_edge &&
                    (wdt_cnt_q == c_wdt_limit);

  assign set_vec = {wdt_cond, uv_active, kill_active};

  always_comb begin
    // Kill debounce: flip when the mismatch run reaches the target length
    kill_deb_d = kill_deb_q;
    kill_cnt_d = 16'd0;
    if (kill_sync_q != kill_deb_q) begin
      if (kill_cnt_inc == c_db_target) begin
        kill_deb_d = ~kill_deb_q;
      end else begin
        kill_cnt_d = kill_cnt_inc;
      end
    end

    // Undervolt debounce, same scheme
    uv_deb_d = uv_deb_q;
    uv_cnt_d = 16'd0;
    if (uv_sync_q != uv_deb_q) begin
      if (uv_cnt_inc == c_db_target) begin
        uv_deb_d = ~uv_deb_q;
      end else begin
        uv_cnt_d = uv_cnt_inc;
      end
    end

    // Watchdog counter; holds at the limit so it can never wrap
    if ((state_q != ST_RUN) || !wdt_enable || hb_edge) begin
      wdt_cnt_d = 24'd0;
    end else if (wdt_cnt_q == c_wdt_limit) begin
      wdt_cnt_d = wdt_cnt_q;
    end else begin
      wdt_cnt_d = wdt_cnt_q + 24'd1;
    end

    latch_d  = latch_q | set_vec;
    state_d  = state_q;
    ho_cnt_d = 16'd0;

    case (state_q)
      ST_SHUTDOWN: begin
        // Re-arm only when nothing is active or about to latch
        if (clear && (set_vec == 3'b000)) begin
          latch_d  = 3'b000;
          ho_cnt_d = 16'd0;
          state_d  = ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: begin
        ho_cnt_d = ho_cnt_q + 16'd1;
        if ((latch_q != 3'b000) || kill_active || uv_active) begin
          state_d = ST_SHUTDOWN;
        end else if (ho_cnt_q == c_ho_last) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (latch_q != 3'b000) begin
          state_d = ST_SHUTDOWN;
        end
      end
      default: begin
        state_d = ST_SHUTDOWN;
      end
    endcase

    shutdown_d = {(state_d != ST_RUN), latch_d};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      kill_meta_q <= 1'b1;
      kill_sync_q <= 1'b1;
      uv_meta_q   <= 1'b0;
      uv_sync_q   <= 1'b0;
      hb_meta_q   <= 1'b0;
      hb_sync_q   <= 1'b0;
      hb_prev_q   <= 1'b0;
      kill_deb_q  <= 1'b1;
      kill_cnt_q  <= 16'd0;
      uv_deb_q    <= 1'b0;
      uv_cnt_q    <= 16'd0;
      wdt_cnt_q   <= 24'd0;
      ho_cnt_q    <= 16'd0;
      latch_q     <= 3'b000;
      state_q     <= ST_SHUTDOWN;
      shutdown_q  <= 4'b1000;
    end else begin
      kill_meta_q <= kill_sw_n;
      kill_sync_q <= kill_meta_q;
      uv_meta_q   <= undervolt;
      uv_sync_q   <= uv_meta_q;
      hb_meta_q   <= heartbeat;
      hb_sync_q   <= hb_meta_q;
      hb_prev_q   <= hb_sync_q;
      kill_deb_q  <= kill_deb_d;
      kill_cnt_q  <= kill_cnt_d;
      uv_deb_q    <= uv_deb_d;
      uv_cnt_q    <= uv_cnt_d;
      wdt_cnt_q   <= wdt_cnt_d;
      ho_cnt_q    <= ho_cnt_d;
      latch_q     <= latch_d;
      state_q     <= state_d;
      shutdown_q  <= shutdown_d;
    end
  end

  assign shutdown = shutdown_q;
  assign state    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_shutdown_monitor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_shutdown_monitor
// Purpose  : Directed bench for shutdown_monitor with DEBOUNCE_CYCLES=4,
//            WDT_CYCLES=20, HOLDOFF_CYCLES=8. Expected values are worked out
//            by hand from the input timing; edge counts below are measured
//            from the clock edge that first samples a changed input.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_shutdown_monitor;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       kill_sw_n;
  logic       undervolt;
  logic       heartbeat;
  logic       wdt_enable;
  logic       clear;
  logic [3:0] shutdown;
  logic [1:0] state;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  shutdown_monitor #(
    .DEBOUNCE_CYCLES(4),
    .WDT_CYCLES     (20),
    .HOLDOFF_CYCLES (8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .kill_sw_n (kill_sw_n),
    .undervolt (undervolt),
    .heartbeat (heartbeat),
    .wdt_enable(wdt_enable),
    .clear     (clear),
    .shutdown  (shutdown),
    .state     (state)
  );

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    kill_sw_n  = 1'b1;
    undervolt  = 1'b0;
    heartbeat  = 1'b0;
    wdt_enable = 1'b0;
    clear      = 1'b0;
    repeat (3) tick();
    chk("reset_shutdown", shutdown, 4'b1000);
    chk("reset_state", {2'b00, state}, 4'b0000);

    // Idle after reset: stays in SHUTDOWN without a clear
    reset_n = 1'b1;
    repeat (10) tick();
    chk("idle_state", {2'b00, state}, 4'b0000);
    chk("idle_shutdown", shutdown, 4'b1000);

    // Clear -> 8 cycles of HOLDOFF -> RUN
    pulse_clear();
    chk("ho0_state", {2'b00, state}, 4'b0001);
    chk("ho0_shutdown", shutdown, 4'b1000);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("ho_state", {2'b00, state}, 4'b0001);
    end
    tick();
    chk("run_state", {2'b00, state}, 4'b0010);
    chk("run_shutdown", shutdown, 4'b0000);

    // 3-cycle kill glitch is filtered out
    kill_sw_n = 1'b0;
    repeat (3) tick();
    kill_sw_n = 1'b1;
    repeat (10) tick();
    chk("glitch_shutdown", shutdown, 4'b0000);
    chk("glitch_state", {2'b00, state}, 4'b0010);

    // Held kill: latch at edge 7, SHUTDOWN at edge 8
    kill_sw_n = 1'b0;
    repeat (6) tick();
    chk("kill_e6", shutdown, 4'b0000);
    tick();
    chk("kill_e7", shutdown, 4'b0001);
    chk("kill_e7_state", {2'b00, state}, 4'b0010);
    tick();
    chk("kill_e8", shutdown, 4'b1001);
    chk("kill_e8_state", {2'b00, state}, 4'b0000);

    // Clear while kill is still active is ignored
    pulse_clear();
    chk("clr_ignored", shutdown, 4'b1001);
    chk("clr_ignored_state", {2'b00, state}, 4'b0000);

    // Release kill, wait, clear -> HOLDOFF -> RUN
    kill_sw_n = 1'b1;
    repeat (8) tick();
    chk("kill_released_latched", shutdown, 4'b1001);
    pulse_clear();
    chk("rearm_state", {2'b00, state}, 4'b0001);
    chk("rearm_shutdown", shutdown, 4'b1000);
    repeat (7) tick();
    chk("rearm_ho7", {2'b00, state}, 4'b0001);
    tick();
    chk("rearm_run", {2'b00, state}, 4'b0010);

    // Watchdog with heartbeat toggling every 10 cycles: no fault
    wdt_enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      repeat (10) tick();
      heartbeat = ~heartbeat;
    end
    chk("wdt_toggle_ok", shutdown, 4'b0000);
    repeat (5) tick();

    // Rise A: counter clears 3 edges later, reaches 20 at edge 23.
    heartbeat = 1'b1;
    repeat (2) tick();
    heartbeat = 1'b0;
    repeat (19) tick();
    // Rise B, timed so its synchronized edge coincides with count 20
    heartbeat = 1'b1;
    repeat (3) tick();
    chk("wdt_edge_at_limit", shutdown, 4'b0000);
    heartbeat = 1'b0;
    // No more beats: count 20 at edge 23 after rise B, latch at 24, SHUTDOWN at 25
    repeat (20) tick();
    chk("wdt_b23", shutdown, 4'b0000);
    tick();
    chk("wdt_b24", shutdown, 4'b0100);
    chk("wdt_b24_state", {2'b00, state}, 4'b0010);
    tick();
    chk("wdt_b25", shutdown, 4'b1100);
    chk("wdt_b25_state", {2'b00, state}, 4'b0000);

    // Undervolt raised with the clear: debounced value turns active in HOLDOFF
    // cycle 5, so the block drops back to SHUTDOWN at edge 6.
    wdt_enable = 1'b0;
    undervolt  = 1'b1;
    pulse_clear();
    chk("uv_ho0", {2'b00, state}, 4'b0001);
    chk("uv_ho0_shutdown", shutdown, 4'b1000);
    repeat (5) tick();
    chk("uv_ho5", {2'b00, state}, 4'b0001);
    tick();
    chk("uv_e6_state", {2'b00, state}, 4'b0000);
    chk("uv_e6_shutdown", shutdown, 4'b1010);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("uv_no_run", {2'b00, state}, 4'b0000);
    end

    // Recover, reach RUN, then reset from RUN
    undervolt = 1'b0;
    repeat (8) tick();
    pulse_clear();
    chk("rec_ho", {2'b00, state}, 4'b0001);
    repeat (8) tick();
    chk("rec_run", {2'b00, state}, 4'b0010);
    chk("rec_run_shutdown", shutdown, 4'b0000);
    reset_n = 1'b0;
    tick();
    chk("rst_run_shutdown", shutdown, 4'b1000);
    chk("rst_run_state", {2'b00, state}, 4'b0000);
    reset_n = 1'b1;
    repeat (12) tick();
    chk("post_rst_state", {2'b00, state}, 4'b0000);
    chk("post_rst_shutdown", shutdown, 4'b1000);
    pulse_clear();
    chk("post_rst_clear", {2'b00, state}, 4'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
